// File: rtl/twice_hls_deadlock_scheduler.sv
// Deadlock supervisor for the twice design's HLS monitors: persistence filtering,
// round-robin selection and valid/ready reporting with sticky flag and saturating count.
module twice_hls_deadlock_scheduler #(
  parameter int unsigned NUM_MON = 4,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned THRESH  = 16,
  parameter int unsigned CW      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_i,
  input  logic [NUM_MON-1:0] block_in_i,
  input  logic               clear_i,
  output logic               report_valid_o,
  output logic [IDX_W-1:0]   report_idx_o,
  input  logic               report_ready_i,
  output logic               deadlock_o,
  output logic [CW-1:0]      report_count_o
);

  localparam logic [1:0]    ST_IDLE   = 2'd0;
  localparam logic [1:0]    ST_REPORT = 2'd1;
  localparam logic [1:0]    ST_HOLD   = 2'd2;
  localparam logic [CW-1:0] THRESH_C  = CW'(THRESH);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MON - 1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q [NUM_MON];
  logic [CW-1:0]      cnt_d [NUM_MON];
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic               report_valid_q, report_valid_d;
  logic [IDX_W-1:0]   report_idx_q, report_idx_d;
  logic               deadlock_q, deadlock_d;
  logic [CW-1:0]      report_count_q, report_count_d;

  logic [NUM_MON-1:0] cand_c;
  logic [NUM_MON-1:0] cand_rot_c;
  logic               grant_vld_c;
  logic [IDX_W-1:0]   grant_idx_c;

  // Persistence counters: any unblocked cycle restarts the run; enable=0 freezes a blocked run.
  always_comb begin
    for (int i = 0; i < NUM_MON; i++) begin
      cnt_d[i]  = cnt_q[i];
      cand_c[i] = enable_i & block_in_i[i] & (cnt_q[i] == THRESH_C);
      if (clear_i || !block_in_i[i]) begin
        cnt_d[i] = '0;
      end else if (enable_i && (cnt_q[i] != THRESH_C)) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Round-robin pick: rotate candidates so the rr pointer lands on bit 0, take the lowest set bit.
  always_comb begin
    cand_rot_c  = NUM_MON'({cand_c, cand_c} >> rr_q);
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
    for (int unsigned k = 0; k < NUM_MON; k++) begin
      if (!grant_vld_c && cand_rot_c[k]) begin
        grant_vld_c = 1'b1;
        grant_idx_c = IDX_W'((32'(rr_q) + k) % NUM_MON);
      end
    end
  end

  // Report FSM; clear overrides everything, including a coincident handshake.
  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    report_valid_d = report_valid_q;
    report_idx_d   = report_idx_q;
    deadlock_d     = deadlock_q;
    report_count_d = report_count_q;
    if (clear_i) begin
      state_d        = ST_IDLE;
      rr_d           = '0;
      report_valid_d = 1'b0;
      deadlock_d     = 1'b0;
      report_count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_vld_c) begin
            report_idx_d   = grant_idx_c;
            report_valid_d = 1'b1;
            state_d        = ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (report_ready_i) begin
            report_valid_d = 1'b0;
            deadlock_d     = 1'b1;
            if (report_count_q != CNT_MAX) begin
              report_count_d = report_count_q + CW'(1);
            end
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Wait for the reported instance to unblock so it cannot be re-reported back to back.
          if (!block_in_i[report_idx_q]) begin
            rr_d    = (report_idx_q == LAST_IDX) ? '0 : report_idx_q + IDX_W'(1);
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d        = ST_IDLE;
          report_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      rr_q           <= '0;
      report_valid_q <= 1'b0;
      report_idx_q   <= '0;
      deadlock_q     <= 1'b0;
      report_count_q <= '0;
      for (int i = 0; i < NUM_MON; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      rr_q           <= rr_d;
      report_valid_q <= report_valid_d;
      report_idx_q   <= report_idx_d;
      deadlock_q     <= deadlock_d;
      report_count_q <= report_count_d;
      for (int i = 0; i < NUM_MON; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign report_valid_o = report_valid_q;
  assign report_idx_o   = report_idx_q;
  assign deadlock_o     = deadlock_q;
  assign report_count_o = report_count_q;

endmodule

// File: tb/tb_twice_hls_deadlock_scheduler.sv
// Bench for twice_hls_deadlock_scheduler: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_twice_hls_deadlock_scheduler;

  localparam int unsigned NUM = 4;
  localparam int unsigned TH  = 16;
  localparam int unsigned MAXCNT = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en, clr, rdy;
  logic [3:0] blk;
  logic       valid, dead;
  logic [1:0] idx;
  logic [7:0] cnt;

  logic       s_en, s_clr, s_rdy;
  logic [3:0] s_blk;
  logic       s_valid, s_dead;
  logic [1:0] s_idx;
  logic [1:0] s_cnt;

  int n_checks = 0;
  int n_errors = 0;

  twice_hls_deadlock_scheduler #(.NUM_MON(4), .IDX_W(2), .THRESH(16), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(en), .block_in_i(blk), .clear_i(clr),
    .report_valid_o(valid), .report_idx_o(idx), .report_ready_i(rdy),
    .deadlock_o(dead), .report_count_o(cnt)
  );

  twice_hls_deadlock_scheduler #(.NUM_MON(4), .IDX_W(2), .THRESH(2), .CW(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .enable_i(s_en), .block_in_i(s_blk), .clear_i(s_clr),
    .report_valid_o(s_valid), .report_idx_o(s_idx), .report_ready_i(s_rdy),
    .deadlock_o(s_dead), .report_count_o(s_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: blocked-run lengths, an outstanding offer, and a pending release.
  int         run [NUM];
  bit [3:0]   m_elig;
  bit         m_offer, m_wait, m_sticky;
  logic [1:0] m_cur, m_ptr, m_j;
  int         m_reports;

  task automatic model_reset();
    for (int i = 0; i < NUM; i++) run[i] = 0;
    m_offer = 1'b0; m_wait = 1'b0; m_sticky = 1'b0;
    m_cur = 2'd0; m_ptr = 2'd0; m_reports = 0;
  endtask

  task automatic model_step();
    for (int i = 0; i < NUM; i++) m_elig[i] = en && blk[i] && (run[i] == TH);
    if (clr) begin
      for (int i = 0; i < NUM; i++) run[i] = 0;
      m_offer = 1'b0; m_wait = 1'b0; m_sticky = 1'b0; m_ptr = 2'd0; m_reports = 0;
    end else begin
      if (m_offer) begin
        if (rdy) begin
          m_offer = 1'b0; m_wait = 1'b1; m_sticky = 1'b1;
          if (m_reports < MAXCNT) m_reports++;
        end
      end else if (m_wait) begin
        if (!blk[m_cur]) begin
          m_ptr  = 2'((int'(m_cur) + 1) % NUM);
          m_wait = 1'b0;
        end
      end else begin
        for (int k = 0; k < NUM; k++) begin
          m_j = 2'((int'(m_ptr) + k) % NUM);
          if (!m_offer && m_elig[m_j]) begin
            m_cur = m_j; m_offer = 1'b1;
          end
        end
      end
      for (int i = 0; i < NUM; i++) begin
        if (!blk[i]) run[i] = 0;
        else if (en && run[i] < TH) run[i]++;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison of the main instance against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        check("cmp_valid", 32'(valid), 32'(m_offer));
        check("cmp_deadlock", 32'(dead), 32'(m_sticky));
        check("cmp_count", 32'(cnt), 32'(m_reports));
        if (m_offer) check("cmp_idx", 32'(idx), 32'(m_cur));
      end
    end
  end

  task automatic wait_valid(input string name, input int budget);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (valid) begin ok = 1'b1; break; end
    end
    check(name, 32'(ok), 1);
  endtask

  task automatic clear_pulse();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    bit  seen;
    int  order [$];
    int  got;
    en = 1'b1; clr = 1'b0; rdy = 1'b0; blk = 4'b0;
    s_en = 1'b1; s_clr = 1'b0; s_rdy = 1'b1; s_blk = 4'b0;

    repeat (2) @(negedge clk);
    check("rst_valid", 32'(valid), 0);
    check("rst_idx", 32'(idx), 0);
    check("rst_deadlock", 32'(dead), 0);
    check("rst_count", 32'(cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single instance confirmed after 16 blocked cycles
    blk = 4'b0010; rdy = 1'b1;
    repeat (16) @(posedge clk);
    @(negedge clk);
    check("t1_valid_c16", 32'(valid), 0);
    @(negedge clk);
    check("t1_valid_c17", 32'(valid), 1);
    check("t1_idx", 32'(idx), 1);
    @(negedge clk);
    check("t1_deadlock", 32'(dead), 1);
    check("t1_count", 32'(cnt), 1);
    blk = 4'b0;
    repeat (3) @(negedge clk);

    // 2: a one-cycle gap restarts persistence
    seen = 1'b0;
    blk = 4'b0100;
    repeat (15) begin @(negedge clk); seen |= valid; end
    blk = 4'b0000;
    @(negedge clk); seen |= valid;
    blk = 4'b0100;
    repeat (15) begin @(negedge clk); seen |= valid; end
    blk = 4'b0000;
    repeat (3) begin @(negedge clk); seen |= valid; end
    check("t2_no_report", 32'(seen), 0);
    check("t2_count", 32'(cnt), 1);

    // 3: round-robin order across three blocked instances
    clear_pulse();
    check("t3_clr_count", 32'(cnt), 0);
    check("t3_clr_deadlock", 32'(dead), 0);
    blk = 4'b1011; rdy = 1'b1;
    for (int c = 0; c < 150 && order.size() < 3; c++) begin
      @(negedge clk);
      if (valid) begin
        order.push_back(int'(idx));
        blk[idx] = 1'b0;
      end
    end
    @(negedge clk);
    check("t3_reports", order.size(), 3);
    for (int k = 0; k < 3; k++) begin
      got = (k < order.size()) ? order[k] : -1;
      check($sformatf("t3_order%0d", k), got, (k == 2) ? 3 : k);
    end
    check("t3_count", 32'(cnt), 3);
    blk = 4'b0;

    // 4: back-pressure holds the offer stable even after block drops
    clear_pulse();
    blk = 4'b0100; rdy = 1'b0;
    wait_valid("t4_timeout", 40);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t4_valid_held", 32'(valid), 1);
      check("t4_idx_held", 32'(idx), 2);
      if (c == 3) blk = 4'b0;
    end
    rdy = 1'b1;
    @(negedge clk);
    check("t4_count", 32'(cnt), 1);
    seen = 1'b0;
    repeat (20) begin @(negedge clk); seen |= valid; end
    check("t4_single", 32'(seen), 0);
    check("t4_count_final", 32'(cnt), 1);

    // 5: clear wins over a coincident handshake, then re-report after 16 cycles
    clear_pulse();
    blk = 4'b1000; rdy = 1'b0;
    wait_valid("t5_timeout", 40);
    rdy = 1'b1; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t5_count", 32'(cnt), 0);
    check("t5_deadlock", 32'(dead), 0);
    check("t5_valid", 32'(valid), 0);
    repeat (16) @(posedge clk);
    @(negedge clk);
    check("t5_valid_c16", 32'(valid), 0);
    @(negedge clk);
    check("t5_valid_c17", 32'(valid), 1);
    check("t5_idx", 32'(idx), 3);
    @(negedge clk);
    check("t5_count_after", 32'(cnt), 1);
    check("t5_deadlock_after", 32'(dead), 1);
    blk = 4'b0;
    repeat (3) @(negedge clk);

    // 6a: asynchronous reset in the middle of an offer
    blk = 4'b0001; rdy = 1'b0;
    wait_valid("t6_timeout", 40);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(valid), 0);
    check("t6_rst_idx", 32'(idx), 0);
    check("t6_rst_deadlock", 32'(dead), 0);
    check("t6_rst_count", 32'(cnt), 0);
    #1 rst_n = 1'b1;
    blk = 4'b0;
    @(negedge clk);

    // 6b: two-bit report counter saturates at 3
    for (int n = 1; n <= 5; n++) begin
      bit ok = 1'b0;
      s_blk = 4'b0001;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (s_valid) begin ok = 1'b1; break; end
      end
      check($sformatf("t6_small_valid%0d", n), 32'(ok), 1);
      check($sformatf("t6_small_idx%0d", n), 32'(s_idx), 0);
      @(negedge clk);
      s_blk = 4'b0;
      @(negedge clk);
      check($sformatf("t6_small_count%0d", n), 32'(s_cnt), (n < 3) ? n : 3);
    end
    check("t6_small_deadlock", 32'(s_dead), 1);

    // Randomized traffic against the model
    clear_pulse();
    repeat (2500) begin
      @(negedge clk);
      for (int i = 0; i < NUM; i++) if ($urandom_range(0, 24) == 0) blk[i] = ~blk[i];
      en  = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 9) < 6);
      clr = ($urandom_range(0, 399) == 0);
    end
    clr = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
